cache_req_arbiter: RTL and testbench
====================================

Name: cache_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one set-associative cache instance (bgn/read/write request port, hit/miss response, state_debug) between NUM_REQ requesters.
- Accepts one request at a time over a valid/ready handshake, issues a single-cycle bgn pulse to the cache and waits for hit/miss.
- Returns the response to the owning requester, then holds off the next grant until the cache has drained back to IDLE, which covers the evict/allocate tail of a write miss.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT, 16, max cycles in WAIT before an error response.
- CACHE_IDLE, 4'd0, cache state_debug encoding for IDLE.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  32*NUM_REQ  request address; slice i = [32*i +: 32]
- req_wdata  in  512*NUM_REQ  write data; slice i = [512*i +: 512]
- req_ready  out  NUM_REQ  one-hot grant/accept
- resp_valid  out  NUM_REQ  one-cycle response strobe to the owner
- resp_hit  out  1  response was a cache hit
- resp_err  out  1  response is a timeout error
- resp_rdata  out  512  read data; shared bus, qualified by resp_valid
- cache_bgn  out  1  cache start pulse
- cache_read  out  1  cache read strobe
- cache_write  out  1  cache write strobe
- cache_address  out  32  cache address
- cache_wdata  out  512  cache write data
- cache_read_data  in  512  cache read data
- cache_hit  in  1  cache hit flag
- cache_miss  in  1  cache miss flag
- cache_state  in  4  cache state_debug
- perf_hits  out  32  hit counter (optional feature)
- perf_misses  out  32  miss counter (optional feature)

Behaviour:
- State machine: IDLE -> ISSUE -> WAIT -> DRAIN -> IDLE. Timeout path is WAIT -> IDLE.
- Reset (rst_n low, asynchronous):
  - state = IDLE, rr pointer = 0, latched op/addr/wdata/owner = 0.
  - All outputs 0.
  - A reset mid-operation abandons the transaction; no response is issued.
- IDLE:
  - Winner = first i with req_valid[i], searching from the rr pointer upward with wrap (pointer NUM_REQ-1 wraps to 0).
  - req_ready[winner] = 1 combinationally, and only in IDLE; all req_ready = 0 in every other state.
  - On the accept edge: latch owner, req_write, addr and wdata of the winner; pointer <= (winner+1) mod NUM_REQ; go ISSUE.
  - No valid request: stay in IDLE, pointer unchanged.
- ISSUE (exactly 1 cycle):
  - cache_bgn = 1; cache_write = latched write; cache_read = ~latched write; cache_address and cache_wdata = latched values.
  - Then go WAIT.
- cache_bgn, cache_read and cache_write are 0 in every state except ISSUE. cache_address and cache_wdata hold their latched values.
- WAIT:
  - First cycle with cache_hit|cache_miss: capture cache_read_data into resp_rdata and cache_hit into resp_hit, with resp_err = 0.
  - resp_valid[owner] = 1 for exactly the next cycle (registered), then go DRAIN.
  - If cache_hit and cache_miss are both high, treat as a hit.
  - Timeout counter starts at 0 on WAIT entry. When it reaches TIMEOUT-1 with no hit or miss: resp_valid[owner] = 1, resp_err = 1, resp_hit = 0, resp_rdata = 0; go IDLE.
- DRAIN:
  - Stay until cache_state == CACHE_IDLE is sampled, then go IDLE.
  - Cache miss stays high during evict/allocate; it is ignored in DRAIN.
- Latency, accept edge to resp_valid high: 4 cycles for a read or write hit.
- Earliest next accept: 2 cycles after resp_valid for a hit; later for a write miss with eviction.
- resp_hit, resp_err and resp_rdata hold their values until the next response.
- Requester behaviour:
  - Must hold req_valid and its payload until req_ready.
  - May drop req_valid without penalty.
  - A request withdrawn while another requester is being served is simply not granted.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined: perf_hits and perf_misses count non-error responses with resp_hit = 1 and 0 respectively. Both are 32-bit, saturate at 32'hFFFF_FFFF, and are reset to 0 by rst_n.
- Undefined: both ports tied to 0 and no counter flops are synthesized.

Test Plan:
- Single read, requester 0, addr {19'd10,7'd5,6'd0}, cache idle:
  - req_ready[0] on the accept cycle, cache_bgn a single 1-cycle pulse with cache_read = 1.
  - On a cache miss: resp_valid[0] 4 cycles after accept, resp_hit = 0, resp_rdata = 512'hCAFEBABE.
- Write then read of the same address from requester 1, data 32'hAAAA_AAAA:
  - Write response has resp_hit = 0 (allocate).
  - Read response has resp_hit = 1 and resp_rdata = 32'hAAAA_AAAA zero-extended.
- Both requesters valid continuously, 4 requests each:
  - Grants alternate 0,1,0,1,...
  - resp_valid goes only to the owner, never overlaps, and no two grants occur inside one transaction.
- Fifth distinct tag written to a full set:
  - Arbiter remains in DRAIN until cache_state returns to 0.
  - The next grant does not occur before the cache has completed evict and allocate.
- Cache model never asserts hit or miss, TIMEOUT = 16:
  - resp_valid[owner] with resp_err = 1 exactly 16 cycles after WAIT entry, then back in IDLE with req_ready available.
- rst_n pulsed low during WAIT:
  - All outputs 0 immediately; no resp_valid follows.
  - rr pointer = 0, so the next grant goes to requester 0 when both requesters are valid.
  - With ARB_PERF_CNT_EN defined, the counters read 0.

Source files
------------

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one set-associative cache port between NUM_REQ requesters.
// Optional macro ARB_PERF_CNT_EN adds saturating hit/miss response counters (perf_hits/perf_misses).
module cache_req_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned TIMEOUT    = 16,
  parameter logic [3:0]  CACHE_IDLE = 4'd0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [32*NUM_REQ-1:0]  req_addr,
  input  logic [512*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic                   resp_hit,
  output logic                   resp_err,
  output logic [511:0]           resp_rdata,
  output logic                   cache_bgn,
  output logic                   cache_read,
  output logic                   cache_write,
  output logic [31:0]            cache_address,
  output logic [511:0]           cache_wdata,
  input  logic [511:0]           cache_read_data,
  input  logic                   cache_hit,
  input  logic                   cache_miss,
  input  logic [3:0]             cache_state,
  output logic [31:0]            perf_hits,
  output logic [31:0]            perf_misses
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 512;
  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [TMO_W-1:0]    r_tmo;
  logic                r_cache_bgn;
  logic                r_cache_read;
  logic                r_cache_write;
  logic [NUM_REQ-1:0]  r_resp_valid;
  logic                r_resp_hit;
  logic                r_resp_err;
  logic [DATA_W-1:0]   r_resp_rdata;

  logic                w_found;
  logic [IDX_W-1:0]    w_winner;
  logic [IDX_W-1:0]    w_idx;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_resp_take;

  // Index arithmetic modulo NUM_REQ; both operands are already below NUM_REQ.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDX_W'(sum);
  endfunction

  // First valid requester at or after the rr pointer, with wrap.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = wrap_add(r_ptr, k);
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_sel_addr  = req_addr[ADDR_W*w_winner +: ADDR_W];
    w_sel_wdata = req_wdata[DATA_W*w_winner +: DATA_W];
  end

  always_comb begin
    req_ready = '0;
    if (r_state == S_IDLE && w_found) req_ready[w_winner] = 1'b1;
  end

  assign w_resp_take = (r_state == S_WAIT) && (cache_hit || cache_miss);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_owner       <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_tmo         <= '0;
      r_cache_bgn   <= 1'b0;
      r_cache_read  <= 1'b0;
      r_cache_write <= 1'b0;
      r_resp_valid  <= '0;
      r_resp_hit    <= 1'b0;
      r_resp_err    <= 1'b0;
      r_resp_rdata  <= '0;
    end else begin
      r_cache_bgn   <= 1'b0;
      r_cache_read  <= 1'b0;
      r_cache_write <= 1'b0;
      r_resp_valid  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_owner       <= w_winner;
            r_addr        <= w_sel_addr;
            r_wdata       <= w_sel_wdata;
            r_ptr         <= wrap_add(w_winner, 1);
            r_cache_bgn   <= 1'b1;
            r_cache_write <= req_write[w_winner];
            r_cache_read  <= ~req_write[w_winner];
            r_state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_tmo   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Simultaneous hit and miss resolves as a hit.
          if (w_resp_take) begin
            r_resp_valid[r_owner] <= 1'b1;
            r_resp_hit            <= cache_hit;
            r_resp_err            <= 1'b0;
            r_resp_rdata          <= cache_read_data;
            r_state               <= S_DRAIN;
          end else if (r_tmo == TMO_LAST) begin
            r_resp_valid[r_owner] <= 1'b1;
            r_resp_hit            <= 1'b0;
            r_resp_err            <= 1'b1;
            r_resp_rdata          <= '0;
            r_state               <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        S_DRAIN: begin
          // Miss may stay high through evict/allocate; only cache_state matters here.
          if (cache_state == CACHE_IDLE) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign resp_valid    = r_resp_valid;
  assign resp_hit      = r_resp_hit;
  assign resp_err      = r_resp_err;
  assign resp_rdata    = r_resp_rdata;
  assign cache_bgn     = r_cache_bgn;
  assign cache_read    = r_cache_read;
  assign cache_write   = r_cache_write;
  assign cache_address = r_addr;
  assign cache_wdata   = r_wdata;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_perf_hits;
  logic [31:0] r_perf_misses;

  // Saturating counters of non-error responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_hits   <= '0;
      r_perf_misses <= '0;
    end else if (w_resp_take) begin
      if (cache_hit) begin
        if (r_perf_hits != 32'hFFFF_FFFF) r_perf_hits <= r_perf_hits + 32'd1;
      end else begin
        if (r_perf_misses != 32'hFFFF_FFFF) r_perf_misses <= r_perf_misses + 32'd1;
      end
    end
  end

  assign perf_hits   = r_perf_hits;
  assign perf_misses = r_perf_misses;
`else
  assign perf_hits   = '0;
  assign perf_misses = '0;
`endif

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter with a small 4-way, 128-set behavioural cache model.
// Cache timing: bgn sampled -> 2 lookup cycles -> hit/miss for one cycle; write miss allocates (evicts if full).
module tb_cache_req_arbiter;

  localparam int unsigned NR = 2;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_write = '0;
  logic [32*NR-1:0]  req_addr  = '0;
  logic [512*NR-1:0] req_wdata = '0;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   resp_valid;
  logic            resp_hit, resp_err;
  logic [511:0]    resp_rdata;
  logic            cache_bgn, cache_read, cache_write;
  logic [31:0]     cache_address;
  logic [511:0]    cache_wdata;
  logic [511:0]    cache_read_data;
  logic            cache_hit, cache_miss;
  logic [3:0]      cache_state;
  logic [31:0]     perf_hits, perf_misses;

  cache_req_arbiter #(.NUM_REQ(NR), .TIMEOUT(16), .CACHE_IDLE(4'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .cache_bgn(cache_bgn), .cache_read(cache_read), .cache_write(cache_write),
    .cache_address(cache_address), .cache_wdata(cache_wdata), .cache_read_data(cache_read_data),
    .cache_hit(cache_hit), .cache_miss(cache_miss), .cache_state(cache_state),
    .perf_hits(perf_hits), .perf_misses(perf_misses)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural cache ----------------
  logic [18:0]  m_tag [128][4];
  logic         m_vld [128][4];
  logic [511:0] m_dat [128][4];
  logic [1:0]   m_rep [128];
  int           m_st   = 0;
  int           m_wait = 0;
  logic         m_w;
  logic [31:0]  m_a;
  logic [511:0] m_wd;
  logic         m_mute = 1'b0;
  logic         m_hitw;
  int           m_hw;
  int           m_way;

  initial begin
    for (int s = 0; s < 128; s++) begin
      m_rep[s] = 2'd0;
      for (int w = 0; w < 4; w++) m_vld[s][w] = 1'b0;
    end
  end

  assign cache_state = 4'(m_st);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= 0; cache_hit <= 1'b0; cache_miss <= 1'b0; cache_read_data <= '0;
    end else begin
      case (m_st)
        0: if (cache_bgn) begin
             m_w <= cache_write; m_a <= cache_address; m_wd <= cache_wdata; m_st <= 1;
           end
        1: m_st <= 2;
        2: begin
          m_hitw = 1'b0; m_hw = 0;
          for (int w = 0; w < 4; w++)
            if (m_vld[m_a[12:6]][w] && m_tag[m_a[12:6]][w] == m_a[31:13]) begin m_hitw = 1'b1; m_hw = w; end
          if (!m_mute) begin
            cache_hit  <= m_hitw;
            cache_miss <= !m_hitw;
            cache_read_data <= m_w ? 512'd0 : (m_hitw ? m_dat[m_a[12:6]][m_hw] : 512'hCAFEBABE);
          end
          if (m_w && m_hitw) m_dat[m_a[12:6]][m_hw] <= m_wd;
          m_st <= 3;
        end
        3: begin
          cache_hit <= 1'b0;
          if (m_w && cache_miss) begin
            m_way = -1;
            for (int w = 0; w < 4; w++) if (!m_vld[m_a[12:6]][w] && m_way < 0) m_way = w;
            if (m_way < 0) begin m_st <= 4; m_wait <= 3; end
            else begin m_st <= 5; m_wait <= 2; end
          end else begin
            cache_miss <= 1'b0; m_st <= 0;
          end
        end
        4: if (m_wait == 1) begin m_st <= 5; m_wait <= 2; end else m_wait <= m_wait - 1;
        5: if (m_wait == 1) begin
             m_way = -1;
             for (int w = 0; w < 4; w++) if (!m_vld[m_a[12:6]][w] && m_way < 0) m_way = w;
             if (m_way < 0) begin
               m_way = int'(m_rep[m_a[12:6]]);
               m_rep[m_a[12:6]] <= m_rep[m_a[12:6]] + 2'd1;
             end
             m_vld[m_a[12:6]][m_way] <= 1'b1;
             m_tag[m_a[12:6]][m_way] <= m_a[31:13];
             m_dat[m_a[12:6]][m_way] <= m_wd;
             cache_miss <= 1'b0; m_st <= 0;
           end else m_wait <= m_wait - 1;
        default: m_st <= 0;
      endcase
    end
  end

  // ---------------- event logs ----------------
  int           cyc = 0;
  int           g_who[$];
  int           g_acc[$];
  int           r_cyc[$];
  logic [NR-1:0] r_vec[$];
  logic         r_hit[$];
  logic         r_err[$];
  logic [511:0] r_dat[$];
  logic [1:0]   bgn_q[$];
  int           onehot_viol = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (|(req_valid & req_ready)) begin
      for (int i = 0; i < NR; i++) if (req_ready[i]) g_who.push_back(i);
      g_acc.push_back(cyc + 1);
    end
    if (|resp_valid) begin
      r_cyc.push_back(cyc); r_vec.push_back(resp_valid);
      r_hit.push_back(resp_hit); r_err.push_back(resp_err); r_dat.push_back(resp_rdata);
      if (!$onehot(resp_valid)) onehot_viol++;
    end
    if (cache_bgn) bgn_q.push_back({cache_read, cache_write});
  end

  task automatic clr_logs();
    g_who.delete(); g_acc.delete(); r_cyc.delete(); r_vec.delete();
    r_hit.delete(); r_err.delete(); r_dat.delete(); bgn_q.delete();
  endtask

  task automatic issue(input int who, input logic wr, input logic [31:0] a, input logic [511:0] d);
    bit done = 1'b0;
    @(posedge clk); #2;
    req_valid[who] = 1'b1; req_write[who] = wr;
    req_addr[32*who +: 32] = a; req_wdata[512*who +: 512] = d;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (req_ready[who]) done = 1'b1;
    end
    if (!done) chk("accept_timeout", 512'(done), 512'd1);
    @(posedge clk); #2;
    req_valid[who] = 1'b0;
  endtask

  task automatic wait_resps(input int n);
    int k = 0;
    while (r_cyc.size() < n && k < 400) begin @(negedge clk); k++; end
    chk("resp_count", 512'(r_cyc.size()), 512'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] A = {19'd10, 7'd5, 6'd0};
  localparam logic [31:0] B = {19'd20, 7'd7, 6'd0};
`ifdef ARB_PERF_CNT_EN
  localparam logic [31:0] EXP_HITS = 32'd2;
  localparam logic [31:0] EXP_MISS = 32'd16;
`else
  localparam logic [31:0] EXP_HITS = 32'd0;
  localparam logic [31:0] EXP_MISS = 32'd0;
`endif

  initial begin
    int n, k;
    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ready", 512'(req_ready), 512'd0);
    chk("rst_resp_valid", 512'(resp_valid), 512'd0);
    chk("rst_bgn", 512'({cache_bgn, cache_read, cache_write}), 512'd0);
    chk("rst_addr", 512'(cache_address), 512'd0);
    chk("rst_rdata", resp_rdata, 512'd0);
    chk("rst_hit_err", 512'({resp_hit, resp_err}), 512'd0);
    chk("rst_perf", 512'({perf_hits, perf_misses}), 512'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single read miss from requester 0
    clr_logs();
    @(posedge clk); #2;
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[31:0] = A;
    #1 chk("rd_ready", 512'(req_ready), 512'd1);
    @(posedge clk); #2 req_valid[0] = 1'b0;
    wait_resps(1);
    chk("rd_latency", 512'(r_cyc[0] - g_acc[0]), 512'd4);
    chk("rd_owner", 512'(r_vec[0]), 512'd1);
    chk("rd_hit", 512'(r_hit[0]), 512'd0);
    chk("rd_rdata", r_dat[0], 512'hCAFEBABE);
    chk("rd_bgn_pulses", 512'(bgn_q.size()), 512'd1);
    chk("rd_bgn_rw", 512'(bgn_q[0]), 512'b10);

    // Write then read same line from requester 1
    clr_logs();
    issue(1, 1'b1, B, 512'hAAAA_AAAA);
    issue(1, 1'b0, B, 512'd0);
    wait_resps(2);
    chk("wr_hit", 512'(r_hit[0]), 512'd0);
    chk("wr_owner", 512'(r_vec[0]), 512'd2);
    chk("wr_bgn_rw", 512'(bgn_q[0]), 512'b01);
    chk("rb_hit", 512'(r_hit[1]), 512'd1);
    chk("rb_rdata", r_dat[1], 512'hAAAA_AAAA);
    repeat (3) @(negedge clk);
    chk("hold_rdata", resp_rdata, 512'hAAAA_AAAA);
    chk("hold_hit", 512'(resp_hit), 512'd1);

    // Both requesters continuously valid: alternate grants
    clr_logs();
    req_write = '0;
    req_addr[31:0]  = {19'd100, 7'd3, 6'd0};
    req_addr[63:32] = {19'd101, 7'd3, 6'd0};
    @(posedge clk); #2 req_valid = 2'b11;
    n = 0; k = 0;
    while (n < 8 && k < 400) begin
      @(negedge clk); k++;
      if (|(req_valid & req_ready)) n++;
    end
    @(posedge clk); #2 req_valid = '0;
    wait_resps(8);
    chk("alt_grants", 512'(g_who.size()), 512'd8);
    for (int i = 0; i < 8; i++) begin
      chk("alt_who", 512'(g_who[i]), 512'(i % 2));
      chk("alt_owner", 512'(r_vec[i]), 512'(1 << g_who[i]));
    end
    for (int i = 0; i < 7; i++) chk("alt_gap", 512'(g_acc[i+1] - r_cyc[i]), 512'd2);
    chk("alt_onehot", 512'(onehot_viol), 512'd0);

    // Fill set 9 with four tags, fifth tag evicts
    clr_logs();
    for (int t = 1; t <= 5; t++) issue(0, 1'b1, {19'(t), 7'd9, 6'd0}, 512'(32'hD000_0000 + 32'(t)));
    issue(0, 1'b0, {19'd5, 7'd9, 6'd0}, 512'd0);
    issue(0, 1'b0, {19'd1, 7'd9, 6'd0}, 512'd0);
    wait_resps(7);
    chk("alloc_gap", 512'(g_acc[4] - r_cyc[3]), 512'd4);
    chk("evict_hit", 512'(r_hit[4]), 512'd0);
    chk("evict_gap", 512'(g_acc[5] - r_cyc[4]), 512'd7);
    chk("evict_rd_hit", 512'(r_hit[5]), 512'd1);
    chk("evict_rd_data", r_dat[5], 512'hD000_0005);
    chk("evicted_rd_hit", 512'(r_hit[6]), 512'd0);
    chk("evicted_rd_data", r_dat[6], 512'hCAFEBABE);

    // Cache silent: timeout error
    clr_logs();
    m_mute = 1'b1;
    issue(0, 1'b0, A, 512'd0);
    wait_resps(1);
    chk("tmo_latency", 512'(r_cyc[0] - g_acc[0]), 512'd17);
    chk("tmo_owner", 512'(r_vec[0]), 512'd1);
    chk("tmo_err", 512'(r_err[0]), 512'd1);
    chk("tmo_hit", 512'(r_hit[0]), 512'd0);
    chk("tmo_rdata", r_dat[0], 512'd0);
    @(posedge clk); #2 req_valid[1] = 1'b1;
    #1 chk("tmo_idle_ready", 512'(req_ready), 512'd2);
    #1 req_valid[1] = 1'b0;
    chk("tmo_err_hold", 512'(resp_err), 512'd1);

    // Reset during WAIT
    chk("perf_hits", 512'(perf_hits), 512'(EXP_HITS));
    chk("perf_misses", 512'(perf_misses), 512'(EXP_MISS));
    clr_logs();
    issue(0, 1'b0, A, 512'd0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("wrst_resp_valid", 512'(resp_valid), 512'd0);
    chk("wrst_err", 512'(resp_err), 512'd0);
    chk("wrst_addr", 512'(cache_address), 512'd0);
    chk("wrst_bgn", 512'({cache_bgn, cache_read, cache_write}), 512'd0);
    chk("wrst_perf", 512'({perf_hits, perf_misses}), 512'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("wrst_no_resp", 512'(r_cyc.size()), 512'd0);
    m_mute = 1'b0;
    clr_logs();
    req_write = '0;
    @(posedge clk); #2 req_valid = 2'b11;
    #1 chk("wrst_rr_grant", 512'(req_ready), 512'd1);
    @(posedge clk); #2 req_valid = '0;
    wait_resps(1);
    chk("wrst_owner", 512'(r_vec[0]), 512'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
